// File: rtl/video_pkg.sv
// Shared video-path types: pixel write bundle and clear FSM states.
package video_pkg;
  localparam int X_W = 9;
  localparam int Y_W = 8;
  localparam int COLOUR_W = 1;

  typedef struct packed {
    logic [X_W-1:0]      x;
    logic [Y_W-1:0]      y;
    logic [COLOUR_W-1:0] colour;
  } pix_t;

  localparam int PIX_W = X_W + Y_W + COLOUR_W;

  typedef enum logic {
    S_IDLE,
    S_CLEAR
  } clr_state_t;
endpackage

// File: rtl/plot_scheduler_if.sv
// Pixel-in handshake plus frame-buffer write port of plot_scheduler.
interface plot_scheduler_if;
  import video_pkg::*;

  logic                pix_valid;
  logic                pix_ready;
  logic [X_W-1:0]      pix_x;
  logic [Y_W-1:0]      pix_y;
  logic [COLOUR_W-1:0] pix_colour;
  logic                plot;
  logic [X_W-1:0]      x;
  logic [Y_W-1:0]      y;
  logic [COLOUR_W-1:0] colour;

  modport master (
    output pix_valid, pix_x, pix_y, pix_colour,
    input  pix_ready, plot, x, y, colour
  );

  modport slave (
    input  pix_valid, pix_x, pix_y, pix_colour,
    output pix_ready, plot, x, y, colour
  );
endinterface

// File: rtl/pixel_fifo.sv
// Small synchronous FIFO with occupancy count; full blocks push even on pop.
module pixel_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 18,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [AW:0]      count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp;
  logic [AW-1:0]    rp;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && (count < (AW+1)'(DEPTH));
  assign do_pop  = pop && (count != '0);
  assign rdata   = mem[rp];

  always_ff @(posedge clk)
    if (do_push) mem[wp] <= wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/plot_scheduler.sv
// Frame-buffer write arbiter: buffered pixels vs full-screen clear sweep.
// `define PLOT_SCHED_STATS_EN adds drop_count and clear_done outputs.
module plot_scheduler
  import video_pkg::*;
#(
  parameter int H_RES      = 320,
  parameter int V_RES      = 240,
  parameter int FIFO_DEPTH = 4
) (
  input  logic CLOCK_50,
  input  logic resetn,
  plot_scheduler_if.slave bus,
  input  logic clear_req,
  output logic clear_busy
`ifdef PLOT_SCHED_STATS_EN
  ,
  output logic [15:0] drop_count,
  output logic        clear_done
`endif
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [X_W:0]   X_LIM  = (X_W+1)'(H_RES);
  localparam logic [Y_W:0]   Y_LIM  = (Y_W+1)'(V_RES);
  localparam logic [X_W-1:0] X_LAST = X_W'(H_RES - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_RES - 1);

  clr_state_t     state;
  clr_state_t     state_nxt;
  logic [X_W-1:0] cx;
  logic [Y_W-1:0] cy;
  logic           last_clr;
  logic [CW-1:0]  fifo_cnt;
  pix_t           in_pix;
  pix_t           head;
  pix_t           wr_pix;
  logic           fifo_ne;
  logic           push;
  logic           gnt_pix;
  logic           gnt_clr;
  logic           clr_last;
  logic           head_ok;
  logic           wr_en;

  assign in_pix        = '{x: bus.pix_x, y: bus.pix_y, colour: bus.pix_colour};
  assign push          = bus.pix_valid & bus.pix_ready;
  assign fifo_ne       = fifo_cnt != '0;
  assign bus.pix_ready = fifo_cnt < CW'(FIFO_DEPTH);
  assign clear_busy    = state == S_CLEAR;
  assign clr_last      = (cx == X_LAST) && (cy == Y_LAST);
  assign head_ok       = ({1'b0, head.x} < X_LIM) && ({1'b0, head.y} < Y_LIM);

  pixel_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (PIX_W)
  ) u_fifo (
    .clk   (CLOCK_50),
    .rst_n (resetn),
    .push  (push),
    .pop   (gnt_pix),
    .wdata (in_pix),
    .rdata (head),
    .count (fifo_cnt)
  );

  // last_clr=1 means the clear was served last, so a pixel wins a tie
  always_comb begin
    gnt_pix = 1'b0;
    gnt_clr = 1'b0;
    unique case (1'b1)
      fifo_ne && clear_busy: begin
        gnt_pix = last_clr;
        gnt_clr = ~last_clr;
      end
      fifo_ne && !clear_busy: gnt_pix = 1'b1;
      !fifo_ne && clear_busy: gnt_clr = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (clear_req) state_nxt = S_CLEAR;
      S_CLEAR: if (gnt_clr && clr_last) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    wr_en  = 1'b0;
    wr_pix = head;
    if (gnt_pix) begin
      wr_en = head_ok;
    end else if (gnt_clr) begin
      wr_en  = 1'b1;
      wr_pix = '{x: cx, y: cy, colour: '0};
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      cx <= '0;
      cy <= '0;
    end else if (state == S_IDLE && clear_req) begin
      cx <= '0;
      cy <= '0;
    end else if (gnt_clr) begin
      if (cx == X_LAST) begin
        cx <= '0;
        cy <= cy + 1'b1;
      end else begin
        cx <= cx + 1'b1;
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn)      last_clr <= 1'b1;
    else if (gnt_pix) last_clr <= 1'b0;
    else if (gnt_clr) last_clr <= 1'b1;
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      bus.plot   <= 1'b0;
      bus.x      <= '0;
      bus.y      <= '0;
      bus.colour <= '0;
    end else begin
      bus.plot <= wr_en;
      if (wr_en) begin
        bus.x      <= wr_pix.x;
        bus.y      <= wr_pix.y;
        bus.colour <= wr_pix.colour;
      end
    end
  end

`ifdef PLOT_SCHED_STATS_EN
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      drop_count <= '0;
      clear_done <= 1'b0;
    end else begin
      clear_done <= gnt_clr && clr_last;
      if (gnt_pix && !head_ok && drop_count != 16'hFFFF)
        drop_count <= drop_count + 1'b1;
    end
  end
`endif
endmodule
